clkgate_seq: RTL

- Sequencer for a two-stage cascaded BUFGCE clock-gate chain: stage 0 gates the root clock, stage 1 gates the stage-0 output.
- Arbitrates clock-on requests from NREQ requesters and drives registered CE0/CE1 in a fixed order: stage 0 enables first and disables last.
- Returns a per-requester ack only once the gated clock has settled.
- Sits in the free-running clk domain, directly in front of the BUFGCE pair.

---
 rtl/clkgate_seq_if.sv | 11 +
 rtl/clkgate_seq.sv | 95 +++++++++
 2 files changed

// File: rtl/clkgate_seq_if.sv
// clkgate_seq_if: request/ack and BUFGCE-enable bundle between requesters and the clock-gate sequencer.
interface clkgate_seq_if #(parameter int NREQ = 4);
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] ack;
    logic            ce0;
    logic            ce1;
    logic            busy;
    logic [2:0]      state_o;
    modport master (output req, input ack, ce0, ce1, busy, state_o);
    modport slave  (input req, output ack, ce0, ce1, busy, state_o);
endinterface

// File: rtl/clkgate_seq.sv
// clkgate_seq: ordered CE0/CE1 sequencer for a cascaded BUFGCE pair with settled-clock acks.
// Optional statistics outputs on_cnt/on_cyc are built when CLKGATE_STAT_EN is defined.
module clkgate_seq #(
    parameter int NREQ     = 4,
    parameter int STG_DLY  = 2,
    parameter int SETTLE   = 4,
    parameter int IDLE_CYC = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    clkgate_seq_if.slave bus
`ifdef CLKGATE_STAT_EN
    ,
    output logic [15:0]  on_cnt,
    output logic [31:0]  on_cyc
`endif
);
    localparam int MX = (STG_DLY > SETTLE) ? ((STG_DLY > IDLE_CYC) ? STG_DLY : IDLE_CYC)
                                           : ((SETTLE > IDLE_CYC) ? SETTLE : IDLE_CYC);
    localparam int CW = $clog2(MX + 1);
    localparam logic [CW-1:0] LD_STG = CW'(STG_DLY - 1);
    localparam logic [CW-1:0] LD_SET = CW'(SETTLE - 1);
    localparam logic [CW-1:0] LD_IDL = CW'(IDLE_CYC - 1);

    typedef enum logic [2:0] {OFF = 3'd0, EN0 = 3'd1, EN1 = 3'd2, ON = 3'd3,
                              IDLE = 3'd4, DIS1 = 3'd5, DIS0 = 3'd6} state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic            anyreq;
    logic            ce0_n, ce1_n, busy_n;
    logic [NREQ-1:0] ack_n;

    assign anyreq      = |bus.req;
    assign bus.state_o = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= OFF;
            cnt      <= '0;
            bus.ce0  <= 1'b0;
            bus.ce1  <= 1'b0;
            bus.busy <= 1'b0;
            bus.ack  <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            bus.ce0  <= ce0_n;
            bus.ce1  <= ce1_n;
            bus.busy <= busy_n;
            bus.ack  <= ack_n;
        end
    end

    // A request pending as DIS0 completes goes straight to EN0, so ce0 is low for exactly one cycle.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            OFF:     if (anyreq) begin state_n = EN0; cnt_n = LD_STG; end
            EN0:     if (cnt == '0) begin state_n = EN1; cnt_n = LD_SET; end else cnt_n = cnt - CW'(1);
            EN1:     if (cnt == '0) state_n = ON; else cnt_n = cnt - CW'(1);
            ON:      if (!anyreq) begin state_n = IDLE; cnt_n = LD_IDL; end
            IDLE:    if (anyreq) state_n = ON;
                     else if (cnt == '0) begin state_n = DIS1; cnt_n = LD_STG; end
                     else cnt_n = cnt - CW'(1);
            DIS1:    if (cnt == '0) state_n = DIS0; else cnt_n = cnt - CW'(1);
            DIS0:    if (anyreq) begin state_n = EN0; cnt_n = LD_STG; end else state_n = OFF;
            default: begin state_n = OFF; cnt_n = '0; end
        endcase
    end

    // Enables are decoded from the next state so every output leaves a flop.
    always_comb begin
        ce0_n  = !(state_n inside {OFF, DIS0});
        ce1_n  = state_n inside {EN1, ON, IDLE};
        busy_n = state_n != OFF;
        ack_n  = (state_n == ON) ? bus.req : '0;
    end

`ifdef CLKGATE_STAT_EN
    // Every entry into EN0 is a power-up of the gated clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            on_cnt <= '0;
            on_cyc <= '0;
        end else begin
            if (state_n == EN0 && state != EN0 && on_cnt != 16'hFFFF)
                on_cnt <= on_cnt + 16'd1;
            if (bus.ce1 && on_cyc != 32'hFFFF_FFFF)
                on_cyc <= on_cyc + 32'd1;
        end
    end
`endif
endmodule
